// File: rtl/int_alu_fu_pkg.sv
// Shared types for the integer ALU functional unit: the alu_op_t opcode
// enum and a helper that classifies branch opcodes.
package int_alu_fu_pkg;

    localparam int unsigned ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLT  = 4'd2,
        OP_SLTU = 4'd3,
        OP_BEQ  = 4'd4,
        OP_BNE  = 4'd5,
        OP_BLT  = 4'd6,
        OP_BGE  = 4'd7,
        OP_BLTU = 4'd8,
        OP_BGEU = 4'd9
    } alu_op_t;

    // Branch opcodes produce a zero result and a condition bit
    function automatic logic is_branch(alu_op_t op);
        return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational add/sub/compare core.
// Ports: op (alu_op_t), rs1/rs2 (XLEN operands) -> result_c (XLEN),
// br_taken_c (branch condition, 0 for non-branches).
// All compares come from one subtraction: signed less-than is
// negative ^ overflow, unsigned less-than is the borrow out of rs1 - rs2.
module alu_core
    import int_alu_fu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  alu_op_t          op,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    output logic [XLEN-1:0]  result_c,
    output logic             br_taken_c
);

    logic [XLEN:0]   diff_ext;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic            zero;
    logic            negative;
    logic            overflow;
    logic            borrow;
    logic            lt_s;
    logic            lt_u;

    // Flag generation from rs1 + ~rs2 + 1; the extra bit is the carry out
    always_comb begin
        sum      = rs1 + rs2;
        diff_ext = {1'b0, rs1} + {1'b0, ~rs2} + (XLEN+1)'(1);
        diff     = diff_ext[XLEN-1:0];
        borrow   = ~diff_ext[XLEN];
        zero     = (diff == '0);
        negative = diff[XLEN-1];
        overflow = (rs1[XLEN-1] != rs2[XLEN-1]) && (diff[XLEN-1] != rs1[XLEN-1]);
        lt_s     = negative ^ overflow;
        lt_u     = borrow;
    end

    // Result and branch-condition select; undefined opcodes fall back to ADD
    always_comb begin
        result_c   = sum;
        br_taken_c = 1'b0;
        case (op)
            OP_SUB:  result_c   = diff;
            OP_SLT:  result_c   = XLEN'(lt_s);
            OP_SLTU: result_c   = XLEN'(lt_u);
            OP_BEQ:  br_taken_c = zero;
            OP_BNE:  br_taken_c = ~zero;
            OP_BLT:  br_taken_c = lt_s;
            OP_BGE:  br_taken_c = ~lt_s;
            OP_BLTU: br_taken_c = lt_u;
            OP_BGEU: br_taken_c = ~lt_u;
            default: result_c   = sum;
        endcase
        if (is_branch(op)) begin
            result_c = '0;
        end
    end

endmodule

// File: rtl/int_alu_fu.sv
// Pipelined integer ALU functional unit with valid/ready issue and
// valid/yumi retirement towards the CDB.
// Ports: clk, reset (sync, active-high); issue side valid_in, ready, op,
// rs1, rs2, rob_tag; result side valid_out, yumi_in, out_rob, out_result,
// out_br_taken, out_from_mem (always 0).
// Optional macro ALU_FLUSH_EN adds input flush, which empties the pipe at
// the next edge and blocks acceptance in that cycle.
// The result is computed combinationally at issue and then carried through
// STAGES (1..4) valid-qualified register stages; out_* are the last stage.
module int_alu_fu
    import int_alu_fu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ROB_W  = 4,
    parameter int          STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready,
    input  alu_op_t          op,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [ROB_W-1:0] rob_tag,
    output logic             valid_out,
    input  logic             yumi_in,
`ifdef ALU_FLUSH_EN
    input  logic             flush,
`endif
    output logic [ROB_W-1:0] out_rob,
    output logic [XLEN-1:0]  out_result,
    output logic             out_br_taken,
    output logic             out_from_mem
);

    localparam int LAST = STAGES - 1;

    logic             flush_w;
    logic             accept;
    logic [XLEN-1:0]  alu_result;
    logic             alu_br_taken;
    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_br;
    logic [STAGES-1:0] stage_en;
    logic [ROB_W-1:0] stage_rob [STAGES];
    logic [XLEN-1:0]  stage_res [STAGES];

`ifdef ALU_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    alu_core #(
        .XLEN (XLEN)
    ) u_alu_core (
        .op         (op),
        .rs1        (rs1),
        .rs2        (rs2),
        .result_c   (alu_result),
        .br_taken_c (alu_br_taken)
    );

    // Stage i may load when it is empty or its contents move on; the last
    // stage moves on only when the CDB takes the result
    always_comb begin
        logic adv;
        stage_en       = '0;
        adv            = ~stage_valid[LAST] | yumi_in;
        stage_en[LAST] = adv;
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv         = ~stage_valid[i] | adv;
            stage_en[i] = adv;
        end
    end

    assign ready  = stage_en[0] & ~flush_w;
    assign accept = valid_in & ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             valid_q;
        logic             valid_d;
        logic             br_q;
        logic             br_d;
        logic [ROB_W-1:0] rob_q;
        logic [ROB_W-1:0] rob_d;
        logic [XLEN-1:0]  res_q;
        logic [XLEN-1:0]  res_d;
        logic             in_valid;
        logic             in_br;
        logic [ROB_W-1:0] in_rob;
        logic [XLEN-1:0]  in_res;

        if (i == 0) begin : g_head
            assign in_valid = accept;
            assign in_br    = alu_br_taken;
            assign in_rob   = rob_tag;
            assign in_res   = alu_result;
        end else begin : g_link
            assign in_valid = stage_valid[i-1];
            assign in_br    = stage_br[i-1];
            assign in_rob   = stage_rob[i-1];
            assign in_res   = stage_res[i-1];
        end

        // Hold while stalled; flush drops every in-flight op
        always_comb begin
            valid_d = valid_q;
            br_d    = br_q;
            rob_d   = rob_q;
            res_d   = res_q;
            if (flush_w) begin
                valid_d = 1'b0;
            end else if (stage_en[i]) begin
                valid_d = in_valid;
                br_d    = in_br;
                rob_d   = in_rob;
                res_d   = in_res;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
                br_q    <= 1'b0;
                rob_q   <= '0;
                res_q   <= '0;
            end else begin
                valid_q <= valid_d;
                br_q    <= br_d;
                rob_q   <= rob_d;
                res_q   <= res_d;
            end
        end

        assign stage_valid[i] = valid_q;
        assign stage_br[i]    = br_q;
        assign stage_rob[i]   = rob_q;
        assign stage_res[i]   = res_q;
    end

    assign valid_out    = stage_valid[LAST];
    assign out_rob      = stage_rob[LAST];
    assign out_result   = stage_res[LAST];
    assign out_br_taken = stage_br[LAST];
    assign out_from_mem = 1'b0;

endmodule
